// File: rtl/clock_pkg.sv
// Shared widths, field limits and set-mode field select encodings for the
// time-of-day counter.
package clock_pkg;

  localparam int unsigned TIME_W  = 6;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HOUR = 2'd2,
    SEL_NONE = 2'd3
  } set_sel_e;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) binary counter for one time field. It steps when inc is
// high and carry_in_en allows it; wrap flags a step taken from MAX.
module wrap_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              carry_in_en,
  output logic [TIME_W-1:0] value,
  output logic              wrap
);

  localparam logic [TIME_W-1:0] MAX_V = TIME_W'(MAX);

  logic [TIME_W-1:0] value_q, value_d;
  logic              step;

  // Next value: hold, increment, or wrap to zero after MAX.
  always_comb begin
    step    = inc && carry_in_en;
    wrap    = step && (value_q == MAX_V);
    value_d = value_q;
    if (step) begin
      value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
    end
  end

  // Field register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/clock_time_counter.sv
// Time-of-day core: prescales clk to a one-second tick and keeps
// seconds/minutes/hours; set mode steps one field at a time with no carry.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned CLKS_PER_SEC = 50_000_000,
  parameter int unsigned HOUR_MAX     = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  input  logic              set_en,
  input  logic [1:0]        set_sel,
  input  logic              set_inc,
  output logic [TIME_W-1:0] sec_out,
  output logic [TIME_W-1:0] min_out,
  output logic [TIME_W-1:0] hour_out,
  output logic              sec_tick,
  output logic              day_wrap
);

  localparam int unsigned    PW         = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLKS_PER_SEC - 1);

  set_sel_e      sel;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          set_sec, set_min, set_hour;
  logic          sec_inc, min_inc, hour_inc;
  logic          min_en, hour_en;
  logic          sec_wrap, min_wrap, hour_wrap;
  logic          sec_tick_q, sec_tick_d;
  logic          day_wrap_q, day_wrap_d;

  assign sel = set_sel_e'(set_sel);

  // Prescaler, second tick and set-mode step requests; set mode pins the
  // prescaler at zero and suppresses the tick.
  always_comb begin
    tick    = run_en && !set_en && (presc_q == PRESC_LAST);
    presc_d = presc_q;
    if (set_en) begin
      presc_d = '0;
    end else if (run_en) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
    set_sec  = set_en && set_inc && (sel == SEL_SEC);
    set_min  = set_en && set_inc && (sel == SEL_MIN);
    set_hour = set_en && set_inc && (sel == SEL_HOUR);
    sec_inc  = tick || set_sec;
  end

  // Minute stage: carry from seconds in run mode; in set mode only its own
  // select may move it, so a seconds wrap there never propagates.
  always_comb begin
    min_inc = sec_wrap || set_min;
    min_en  = !set_en || (sel == SEL_MIN);
  end

  // Hour stage, gated the same way as the minute stage.
  always_comb begin
    hour_inc = min_wrap || set_hour;
    hour_en  = !set_en || (sel == SEL_HOUR);
  end

  // Pulse outputs, registered so they align with the new field values.
  always_comb begin
    sec_tick_d = tick;
    day_wrap_d = tick && sec_wrap && min_wrap && hour_wrap;
  end

  // Prescaler and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  wrap_counter #(.MAX(SEC_MAX)) u_sec (
    .clk         (clk),
    .rst         (rst),
    .inc         (sec_inc),
    .carry_in_en (1'b1),
    .value       (sec_out),
    .wrap        (sec_wrap)
  );

  wrap_counter #(.MAX(MIN_MAX)) u_min (
    .clk         (clk),
    .rst         (rst),
    .inc         (min_inc),
    .carry_in_en (min_en),
    .value       (min_out),
    .wrap        (min_wrap)
  );

  wrap_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk         (clk),
    .rst         (rst),
    .inc         (hour_inc),
    .carry_in_en (hour_en),
    .value       (hour_out),
    .wrap        (hour_wrap)
  );

  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter with CLKS_PER_SEC=4, HOUR_MAX=23.
module tb_clock_time_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_en;
  logic       set_en;
  logic [1:0] set_sel;
  logic       set_inc;
  logic [5:0] sec_out, min_out, hour_out;
  logic       sec_tick, day_wrap;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  clock_time_counter #(.CLKS_PER_SEC(4), .HOUR_MAX(23)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_en   (run_en),
    .set_en   (set_en),
    .set_sel  (set_sel),
    .set_inc  (set_inc),
    .sec_out  (sec_out),
    .min_out  (min_out),
    .hour_out (hour_out),
    .sec_tick (sec_tick),
    .day_wrap (day_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int h, input int m, input int s,
                         input logic tk, input logic dw);
    chk({tag, ".hour"}, 32'(hour_out), 32'(h));
    chk({tag, ".min"},  32'(min_out),  32'(m));
    chk({tag, ".sec"},  32'(sec_out),  32'(s));
    chk({tag, ".tick"}, 32'(sec_tick), 32'(tk));
    chk({tag, ".dwrap"}, 32'(day_wrap), 32'(dw));
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold set_inc for n cycles on the given field.
  task automatic pulses(input logic [1:0] sel, input int n);
    set_sel = sel;
    set_inc = 1'b1;
    step(n);
    set_inc = 1'b0;
  endtask

  // Reset for one edge, checking the asynchronous clear, then release.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_all(tag, 0, 0, 0, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run_en = 1'b0; set_en = 1'b0; set_sel = 2'd3; set_inc = 1'b0;

    // Reset state while rst is held across clock edges.
    #12;
    chk_all("reset", 0, 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; run_en = 1'b1;

    // Run from reset: first second after 4 edges, tick exactly one cycle.
    step(3);
    chk_all("run3", 0, 0, 0, 1'b0, 1'b0);
    step(1);
    chk_all("run4", 0, 0, 1, 1'b1, 1'b0);
    step(1);
    chk_all("run5", 0, 0, 1, 1'b0, 1'b0);
    step(235);
    chk_all("run240", 0, 1, 0, 1'b1, 1'b0);

    // Day wrap: set 23:59:59 then run one second.
    do_reset("rst_a");
    set_en = 1'b1;
    pulses(2'd0, 59);
    pulses(2'd1, 59);
    pulses(2'd2, 23);
    chk_all("set_235959", 23, 59, 59, 1'b0, 1'b0);
    set_en = 1'b0;
    step(3);
    chk_all("dw_pre", 23, 59, 59, 1'b0, 1'b0);
    step(1);
    chk_all("dw_edge", 0, 0, 0, 1'b1, 1'b1);
    step(1);
    chk_all("dw_post", 0, 0, 0, 1'b0, 1'b0);

    // No carry in set mode.
    set_en = 1'b1;
    pulses(2'd0, 5);
    pulses(2'd1, 59);
    pulses(2'd2, 25);
    chk_all("hour_wrap_set", 1, 59, 5, 1'b0, 1'b0);
    pulses(2'd1, 1);
    chk_all("min_wrap_set", 1, 0, 5, 1'b0, 1'b0);
    pulses(2'd0, 55);
    chk_all("sec_wrap_set", 1, 0, 0, 1'b0, 1'b0);
    pulses(2'd3, 3);
    chk_all("sel_none", 1, 0, 0, 1'b0, 1'b0);

    // Set priority over the tick edge at prescaler 3.
    set_en = 1'b0;
    step(3);
    set_en = 1'b1;
    step(1);
    chk_all("prio_edge", 1, 0, 0, 1'b0, 1'b0);
    step(2);
    // set_inc/set_sel must be ignored outside set mode.
    set_en = 1'b0; set_sel = 2'd0; set_inc = 1'b1;
    step(3);
    chk_all("prio_wait", 1, 0, 0, 1'b0, 1'b0);
    step(1);
    chk_all("prio_tick", 1, 0, 1, 1'b1, 1'b0);
    set_inc = 1'b0;

    // Pause at 00:00:02 with prescaler 2.
    do_reset("rst_b");
    step(8);
    chk_all("pause_at2", 0, 0, 2, 1'b1, 1'b0);
    step(2);
    run_en = 1'b0;
    step(10);
    chk_all("paused", 0, 0, 2, 1'b0, 1'b0);
    run_en = 1'b1;
    step(1);
    chk_all("resume1", 0, 0, 2, 1'b0, 1'b0);
    step(1);
    chk_all("resume2", 0, 0, 3, 1'b1, 1'b0);

    // Asynchronous reset mid-run from 05:10:30.
    do_reset("rst_c");
    set_en = 1'b1;
    pulses(2'd0, 30);
    pulses(2'd1, 10);
    pulses(2'd2, 5);
    set_en = 1'b0;
    step(2);
    chk_all("at051030", 5, 10, 30, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 1'b0, 1'b0);
    step(2);
    #3;
    rst = 1'b0;
    step(3);
    chk_all("rel3", 0, 0, 0, 1'b0, 1'b0);
    step(1);
    chk_all("rel4", 0, 0, 1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_time_counter.md
Name: clock_time_counter

Overview:
- Time-of-day core of the clock. Divides the system clock down to a 1 Hz tick and keeps seconds, minutes and hours as plain binary counters.
- Each 6-bit field feeds directly into a binary-to-BCD converter instance, one per field, on the way to the display path.
- Provides a set mode: the user steps a selected field with single-cycle increment pulses while timekeeping is frozen.

Parameters:
- CLKS_PER_SEC, 50_000_000: system clock cycles per second tick; legal range ≥2. Benches use 4.
- HOUR_MAX, 23: last hour value before the hour field wraps to 0; legal range 1..59.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- run_en  in  1  high = timekeeping runs; low = prescaler and fields freeze.
- set_en  in  1  high = set mode.
- set_sel  in  2  field select in set mode: 0 = sec, 1 = min, 2 = hour, 3 = none.
- set_inc  in  1  single-cycle pulse (debounced upstream); steps the selected field by one.
- sec_out  out  6  seconds, 0..59.
- min_out  out  6  minutes, 0..59.
- hour_out  out  6  hours, 0..HOUR_MAX.
- sec_tick  out  1  one-cycle pulse on each timekeeping second increment.
- day_wrap  out  1  one-cycle pulse on HOUR_MAX:59:59 -> 00:00:00.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset:
  - While rst is high, all outputs and the prescaler are 0, immediately and without waiting for a clock edge.
  - Reset asserted mid-count or mid-set aborts the operation with no partial update.
  - After release, counting restarts from prescaler 0.
- Prescaler:
  - Width is clog2(CLKS_PER_SEC). It counts 0..CLKS_PER_SEC-1 while run_en=1 and set_en=0.
  - On the edge where prescaler == CLKS_PER_SEC-1, the prescaler returns to 0 and a second increment occurs.
- Second increment:
  - sec +1. At 59, sec -> 0 and carry into min.
  - min at 59 -> 0 and carry into hour.
  - hour at HOUR_MAX -> 0.
  - All fields update on the same edge.
  - sec_tick is registered high for exactly the cycle in which the new sec_out value is first visible.
  - day_wrap is high in that same cycle only when all three fields wrapped.
- Latency: sec_out changes CLKS_PER_SEC cycles after prescaler 0 is loaded.
- Pause: when run_en=0 and set_en=0, the prescaler and all fields hold and no pulses are generated.
- Set mode (set_en=1):
  - Set mode takes priority over run_en and over a coincident tick edge. The prescaler is held at 0, so no tick is lost-counted.
  - Each cycle with set_inc=1 increments the selected field by one, wrapping at its own maximum (59 or HOUR_MAX).
  - Increments in set mode never carry into the next field.
  - set_sel=3 ignores set_inc.
  - sec_tick and day_wrap stay 0 in set mode.
- Exit from set mode: the prescaler starts from 0, so the first tick arrives a full CLKS_PER_SEC cycles after set_en falls (if run_en=1).
- Inputs set_inc and set_sel are ignored when set_en=0.
- All outputs are registered. There is no combinational path from input to output.
- Field values are always within legal range, so the downstream BCD stage never sees values above 59.

Decomposition:
- Shared package clock_pkg holds:
  - TIME_W = 6.
  - SEC_MAX = 59 and MIN_MAX = 59.
  - SEL_SEC, SEL_MIN, SEL_HOUR and SEL_NONE encodings for set_sel.
- Sub-module wrap_counter, parameterised by MAX:
  - Inputs: clk, rst, inc, carry_in_en. Outputs: value, wrap (combinational, high when inc is asserted at MAX).
  - Instantiated three times, chained through wrap in run mode and gated per set_sel in set mode.
- The prescaler and pulse registers stay in the top level.

Test Plan (CLKS_PER_SEC=4, HOUR_MAX=23):
- Run from reset: run_en=1, set_en=0, 4 cycles -> sec_out=1 with a sec_tick pulse of exactly 1 cycle. After 240 cycles total -> min_out=1, sec_out=0.
- Day wrap:
  - Set mode: set_sel=0 with 59 pulses, set_sel=1 with 59 pulses, set_sel=2 with 23 pulses -> 23:59:59.
  - Exit set mode and run 4 cycles -> 00:00:00 with day_wrap and sec_tick both high for the same single cycle.
- No carry in set mode: hour=0, set_sel=2, 25 set_inc pulses -> hour_out=1, min_out and sec_out unchanged. min=59 plus one pulse on set_sel=1 -> min_out=0, hour_out unchanged.
- Set priority: set_en rises on the cycle the prescaler is 3 -> no increment and no sec_tick. Drop set_en -> next sec_tick exactly 4 cycles later.
- Pause: at 00:00:02 with prescaler 2, run_en=0 for 10 cycles -> outputs frozen. run_en=1 -> sec_out=3 two cycles later.
- Async reset mid-run: at 05:10:30, assert rst between clock edges -> all outputs 0 before the next edge. Release -> first sec_tick 4 cycles after release.
